rr_arb: RTL
===========

# rr_arb

Round-robin arbiter that shares one downstream channel among `WIDTH` requesters. The grant is registered and held for a multi-beat transfer until the requester's last beat is accepted. Winner selection is a rotating-priority scan: the first set request at or above the rotating pointer wins, wrapping to the lowest index. The block sits in front of shared ROB write and retire ports and any other single-consumer resource.

## Interface
- `WIDTH`, 16: number of requesters; minimum 2, need not be a power of two.
- `MAX_BEATS`, 64: beats accepted under one grant before a forced release; minimum 1.
- `IW`, derived: `$clog2(WIDTH)`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  WIDTH  request per requester; held high until that requester's last beat is accepted.
- `last`  in  WIDTH  per-requester last-beat flag; only `last[gnt_idx]` is used.
- `out_rdy`  in  1  downstream accepts the current beat.
- `gnt`  out  WIDTH  one-hot grant, registered.
- `gnt_idx`  out  IW  index of the granted requester, registered.
- `gnt_vld`  out  1  a grant is active (IDLE=0, BUSY=1).
- `drop_err`  out  1  one-cycle pulse: the granted requester dropped `req` before its last beat.
- `tmo`  out  1  one-cycle pulse: grant force-released at `MAX_BEATS`.

## Operation
- State: `st` (IDLE or BUSY), `ptr` [IW-1:0], `gnt_idx`, `gnt`, and `beats` (width `$clog2(MAX_BEATS+1)`).
- Selection function `sel(req, p)`:
  - Lowest set index i with i ≥ p wins; if none, the lowest set index overall.
  - Result "none" when `req` is all zero.
- Beat accept: `gnt_vld & out_rdy`.
- Release event in BUSY, in priority order:
  - (a) `req[gnt_idx]==0`: drop. Pulse `drop_err`; no beat is counted, even if `out_rdy`.
  - (b) accept with `last[gnt_idx]==1`: normal release.
  - (c) accept with `beats==MAX_BEATS-1`: forced release. Pulse `tmo`.
- On release:
  - `ptr <= (gnt_idx+1) mod WIDTH`.
  - `beats <= 0`.
  - In the same cycle, evaluate `sel(req & ~gnt, (gnt_idx+1) mod WIDTH)`, which excludes the releasing requester this cycle.
  - If a winner exists, stay BUSY with the new grant (back-to-back). Otherwise go to IDLE.
- Accept without release: `beats <= beats+1`; grant unchanged.
- BUSY with `out_rdy=0` and `req[gnt_idx]=1`: everything holds.
- IDLE: if `sel(req, ptr)` returns a winner, load `gnt`/`gnt_idx`, go BUSY, `beats <= 0`. `ptr` is not changed.
- `gnt` is always one-hot or zero. It is zero exactly when in IDLE.
- `gnt_idx` keeps its last value in IDLE; it is don't-care there.
- Reset (`rst_n=0` at the edge, including mid-transfer):
  - `st=IDLE`, `ptr=0`, `gnt=0`, `gnt_idx=0`, `gnt_vld=0`, `beats=0`, `drop_err=0`, `tmo=0`.
  - Any in-flight grant is abandoned with no pulse.

## Timing
- Request to grant: a request seen in IDLE at edge N gives `gnt_vld=1` from cycle N+1. One cycle of latency.
- Back-to-back: a release at edge N with another request pending gives the new grant in cycle N+1, with no idle cycle.
- With only one requester active, that requester is re-granted after one IDLE cycle, because it is excluded in its release cycle.
- `drop_err` and `tmo` are registered, asserted for exactly the cycle after the event. They are never both high.
- `ptr` advances only on release, never on a grant from IDLE. Fairness bound: a continuously requesting requester waits at most WIDTH-1 grants.
- No combinational path from `req`, `last` or `out_rdy` to any output.

## Test plan
- Reset: assert `rst_n=0` mid-BUSY with `gnt=4'b0100` → next cycle `gnt=0`, `gnt_vld=0`, `ptr=0`, no pulses. The first grant after reset with `req=4'b1111` is index 0.
- Rotation (WIDTH=4): `req=4'b1011`, `last` all 1, `out_rdy=1` → grants 0,1,3,0,1,3… in consecutive cycles, with no gaps.
- Backpressure: granted index 2, `out_rdy=0` for 5 cycles while `req=4'b1111` → `gnt=4'b0100` is held all 5 cycles. `beats` stays 0.
- Multi-beat: `req[2]` with `last[2]=0` for 3 accepted beats, then `last[2]=1`, with `req[0]` waiting → `gnt[2]` is held 4 accepts, then `gnt=4'b0001` the next cycle.
- Drop: index 1 is granted, `req` changes to `4'b1001` before `last` → `drop_err` pulses one cycle, the grant moves to index 3, and `ptr` becomes 2.
- Timeout: `MAX_BEATS=8`, `last` held 0, `out_rdy=1` → release after the 8th accept, `tmo` pulses once, and the next requester is granted. With no other requester, the same requester is re-granted after one IDLE cycle.

Source files
------------

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter with a registered grant held across multi-beat transfers,
// drop detection and a forced release after MAX_BEATS accepted beats.
module rr_arb #(
    parameter int WIDTH     = 16,
    parameter int MAX_BEATS = 64,
    parameter int IW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] last,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_vld,
    output logic             drop_err,
    output logic             tmo
);
    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, BUSY} st_e;

    st_e              st_q;
    logic [IW-1:0]    ptr_q, idx_q;
    logic [WIDTH-1:0] gnt_q;
    logic [BW-1:0]    beats_q;
    logic             drop_q, tmo_q;

    // {found, index}: first set bit at or above p, else lowest set bit overall
    function automatic logic [IW:0] sel(input logic [WIDTH-1:0] r, input logic [IW-1:0] p);
        logic          hi_f, lo_f;
        logic [IW-1:0] hi_i, lo_i;
        hi_f = 1'b0;
        lo_f = 1'b0;
        hi_i = '0;
        lo_i = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r[i]) begin
                lo_f = 1'b1;
                lo_i = IW'(i);
                if (i >= int'(p)) begin
                    hi_f = 1'b1;
                    hi_i = IW'(i);
                end
            end
        end
        return {hi_f | lo_f, hi_f ? hi_i : lo_i};
    endfunction

    logic          busy, drop_d, done_d, tmo_d, rel_d, win_d;
    logic [IW-1:0] nxt_d, win_idx_d;

    always_comb begin
        busy   = st_q == BUSY;
        nxt_d  = idx_q == IW'(WIDTH - 1) ? '0 : idx_q + IW'(1);
        drop_d = busy & ~req[idx_q];
        done_d = busy & req[idx_q] & out_rdy & last[idx_q];
        tmo_d  = busy & req[idx_q] & out_rdy & ~last[idx_q] & (beats_q == BW'(MAX_BEATS - 1));
        rel_d  = drop_d | done_d | tmo_d;
        // the releasing requester is masked out so it cannot win its own release cycle
        {win_d, win_idx_d} = rel_d ? sel(req & ~gnt_q, nxt_d) : sel(req, ptr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q    <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            beats_q <= '0;
            drop_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            drop_q <= drop_d;
            tmo_q  <= tmo_d;
            if (st_q == IDLE) begin
                if (win_d) begin
                    st_q    <= BUSY;
                    idx_q   <= win_idx_d;
                    gnt_q   <= WIDTH'(1) << win_idx_d;
                    beats_q <= '0;
                end
            end else if (rel_d) begin
                ptr_q   <= nxt_d;
                beats_q <= '0;
                if (win_d) begin
                    idx_q <= win_idx_d;
                    gnt_q <= WIDTH'(1) << win_idx_d;
                end else begin
                    st_q  <= IDLE;
                    gnt_q <= '0;
                end
            end else if (out_rdy) begin
                beats_q <= beats_q + BW'(1);
            end
        end
    end

    assign gnt      = gnt_q;
    assign gnt_idx  = idx_q;
    assign gnt_vld  = st_q == BUSY;
    assign drop_err = drop_q;
    assign tmo      = tmo_q;
endmodule
